// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes framed UART bytes into register-file and ALU
// operations, and returns read/ALU results to the TX FIFO LSB byte first.
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int OPA_ADDR      = 0,
    parameter int OPB_ADDR      = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic                     RX_ERR,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_VLD,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]    RF_ADDR,
    output logic                     RF_WR_EN,
    output logic                     RF_RD_EN,
    output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD
);

    localparam int NB = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int CW = $clog2(NB + 1);

    localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_RUN = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        ALU_A,
        ALU_B,
        ALU_FN,
        ALU_WAIT,
        TX_SEND
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    rf_addr_q, rf_addr_d;
    logic                     rf_wr_en_q, rf_wr_en_d;
    logic                     rf_rd_en_q, rf_rd_en_d;
    logic [DATA_WIDTH-1:0]    rf_wr_data_q, rf_wr_data_d;
    logic                     alu_en_q, alu_en_d;
    logic [3:0]               alu_fun_q, alu_fun_d;
    logic [ALU_OUT_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [CW-1:0]            tx_cnt_q, tx_cnt_d;

    logic byte_ok;
    logic byte_bad;

    assign byte_ok  = RX_D_VLD & ~RX_ERR;
    assign byte_bad = RX_D_VLD & RX_ERR;

    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_wr_data_d = rf_wr_data_q;
        alu_en_d     = alu_en_q;
        alu_fun_d    = alu_fun_q;
        tx_buf_d     = tx_buf_q;
        tx_cnt_d     = tx_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (byte_ok) begin
                    case (RX_P_DATA)
                        OP_WR:   state_d = WR_ADDR;
                        OP_RD:   state_d = RD_ADDR;
                        OP_ALU:  state_d = ALU_A;
                        OP_RUN:  state_d = ALU_FN;
                        default: state_d = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (byte_bad) begin
                    state_d = IDLE;
                end else if (byte_ok) begin
                    rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (byte_bad) begin
                    state_d = IDLE;
                end else if (byte_ok) begin
                    rf_wr_data_d = RX_P_DATA;
                    rf_wr_en_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            RD_ADDR: begin
                if (byte_bad) begin
                    state_d = IDLE;
                end else if (byte_ok) begin
                    rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RF_RD_VLD) begin
                    tx_buf_d = ALU_OUT_WIDTH'(RF_RD_DATA);
                    tx_cnt_d = CW'(1);
                    state_d  = TX_SEND;
                end
            end
            ALU_A: begin
                if (byte_bad) begin
                    state_d = IDLE;
                end else if (byte_ok) begin
                    rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ALU_B;
                end
            end
            ALU_B: begin
                if (byte_bad) begin
                    state_d = IDLE;
                end else if (byte_ok) begin
                    rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ALU_FN;
                end
            end
            ALU_FN: begin
                if (byte_bad) begin
                    state_d = IDLE;
                end else if (byte_ok) begin
                    alu_fun_d = RX_P_DATA[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    tx_buf_d = ALU_OUT;
                    tx_cnt_d = CW'(NB);
                    alu_en_d = 1'b0;
                    state_d  = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!FIFO_FULL) begin
                    tx_buf_d = tx_buf_q >> DATA_WIDTH;
                    tx_cnt_d = tx_cnt_q - CW'(1);
                    if (tx_cnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            rf_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            tx_buf_q     <= '0;
            tx_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            tx_buf_q     <= tx_buf_d;
            tx_cnt_q     <= tx_cnt_d;
        end
    end

    assign RF_ADDR     = rf_addr_q;
    assign RF_WR_EN    = rf_wr_en_q;
    assign RF_RD_EN    = rf_rd_en_q;
    assign RF_WR_DATA  = rf_wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    // The gate opens and closes with the ALU enable; it is only set in ALU_WAIT.
    assign CLK_GATE_EN = alu_en_q;
    // Push is combinational on FIFO_FULL so a full FIFO never sees a strobe.
    assign TX_D_VLD    = (state_q == TX_SEND) && !FIFO_FULL;
    assign TX_P_DATA   = tx_buf_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: RF/ALU/FIFO stand-ins plus a frame-level model
// that predicts writes, reads, ALU launches and TX bytes.
module tb_sys_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic        RX_ERR = 1'b0;
    logic [7:0]  RF_RD_DATA;
    logic        RF_RD_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        FIFO_FULL;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN;
    logic        RF_RD_EN;
    logic [7:0]  RF_WR_DATA;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    sys_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .FIFO_FULL(FIFO_FULL),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
        .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;
    int proto_err = 0;
    bit full_force = 0;
    bit full_rand = 0;

    logic [7:0]  rf_mem [16];
    logic [7:0]  model_rf [16];
    logic [15:0] got_wr[$], exp_wr[$];
    logic [15:0] got_rd[$], exp_rd[$];
    logic [15:0] got_tx[$], exp_tx[$];
    logic [15:0] got_fun[$], exp_fun[$];

    function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (f)
            4'd0:    return wa + wb;
            4'd1:    return wa - wb;
            4'd2:    return wa * wb;
            default: return {a, b} ^ {12'h000, f};
        endcase
    endfunction

    function automatic bit q_same(input logic [15:0] a[$], input logic [15:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    // Observer: records every side effect and flags handshake violations.
    logic prev_ok = 0, prev_wr = 0, prev_rd = 0, prev_alu = 0;
    always @(negedge CLK) begin
        if (RST) begin
            if (RF_WR_EN) begin
                got_wr.push_back({4'h0, RF_ADDR, RF_WR_DATA});
                rf_mem[RF_ADDR] = RF_WR_DATA;
                if (!prev_ok || prev_wr) proto_err++;
            end
            if (RF_RD_EN) begin
                got_rd.push_back({12'h000, RF_ADDR});
                if (!prev_ok || prev_rd) proto_err++;
            end
            if (TX_D_VLD) begin
                got_tx.push_back({8'h00, TX_P_DATA});
                if (FIFO_FULL) proto_err++;
            end
            if (ALU_EN && !prev_alu) got_fun.push_back({12'h000, ALU_FUN});
            if (CLK_GATE_EN !== ALU_EN) proto_err++;
        end
        prev_ok  = RX_D_VLD && !RX_ERR;
        prev_wr  = RF_WR_EN;
        prev_rd  = RF_RD_EN;
        prev_alu = ALU_EN;
    end

    initial begin
        logic [3:0] a;
        int d;
        RF_RD_VLD = 0;
        RF_RD_DATA = '0;
        forever begin
            @(negedge CLK);
            if (RST && RF_RD_EN) begin
                a = RF_ADDR;
                d = $urandom_range(1, 3);
                repeat (d) @(posedge CLK);
                #1;
                RF_RD_DATA = rf_mem[a];
                RF_RD_VLD = 1;
                @(posedge CLK);
                #1;
                RF_RD_VLD = 0;
            end
        end
    end

    initial begin
        bit seen;
        int d;
        seen = 0;
        ALU_OUT_VLD = 0;
        ALU_OUT = '0;
        forever begin
            @(negedge CLK);
            if (!ALU_EN) seen = 0;
            if (RST && ALU_EN && !seen) begin
                seen = 1;
                d = $urandom_range(1, 4);
                repeat (d) @(posedge CLK);
                #1;
                ALU_OUT = alu_ref(ALU_FUN, rf_mem[0], rf_mem[1]);
                ALU_OUT_VLD = 1;
                @(posedge CLK);
                #1;
                ALU_OUT_VLD = 0;
            end
        end
    end

    initial begin
        FIFO_FULL = 0;
        forever begin
            @(posedge CLK);
            #1;
            FIFO_FULL = full_force || (full_rand && $urandom_range(0, 2) == 0);
        end
    end

    task automatic clr();
        got_wr.delete(); exp_wr.delete();
        got_rd.delete(); exp_rd.delete();
        got_tx.delete(); exp_tx.delete();
        got_fun.delete(); exp_fun.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit err);
        int g;
        @(posedge CLK);
        #1;
        RX_P_DATA = b;
        RX_ERR = err;
        RX_D_VLD = 1;
        @(posedge CLK);
        #1;
        RX_D_VLD = 0;
        RX_ERR = 0;
        g = $urandom_range(0, 2);
        repeat (g) @(posedge CLK);
    endtask

    // Model the frame's effects, send it, then wait for any TX reply.
    task automatic do_frame(input logic [7:0] b0, b1, b2, b3, input int n, input int err_at, input bit wait_tx);
        int eff;
        int t;
        logic [15:0] r;
        eff = (err_at < n) ? err_at : n;
        case (b0)
            8'hAA: if (eff >= 3) begin
                exp_wr.push_back({4'h0, b1[3:0], b2});
                model_rf[b1[3:0]] = b2;
            end
            8'hBB: if (eff >= 2) begin
                exp_rd.push_back({12'h000, b1[3:0]});
                exp_tx.push_back({8'h00, model_rf[b1[3:0]]});
            end
            8'hCC: begin
                if (eff >= 2) begin
                    exp_wr.push_back({8'h00, b1});
                    model_rf[0] = b1;
                end
                if (eff >= 3) begin
                    exp_wr.push_back({8'h01, b2});
                    model_rf[1] = b2;
                end
                if (eff >= 4) begin
                    r = alu_ref(b3[3:0], model_rf[0], model_rf[1]);
                    exp_fun.push_back({12'h000, b3[3:0]});
                    exp_tx.push_back({8'h00, r[7:0]});
                    exp_tx.push_back({8'h00, r[15:8]});
                end
            end
            8'hDD: if (eff >= 2) begin
                r = alu_ref(b1[3:0], model_rf[0], model_rf[1]);
                exp_fun.push_back({12'h000, b1[3:0]});
                exp_tx.push_back({8'h00, r[7:0]});
                exp_tx.push_back({8'h00, r[15:8]});
            end
            default: ;
        endcase
        for (int i = 0; i < n; i++) begin
            case (i)
                0: send_byte(b0, i == err_at);
                1: send_byte(b1, i == err_at);
                2: send_byte(b2, i == err_at);
                default: send_byte(b3, i == err_at);
            endcase
            if (i == err_at) break;
        end
        if (wait_tx) begin
            t = 0;
            while (got_tx.size() < exp_tx.size() && t < 300) begin
                @(posedge CLK);
                t++;
            end
            checks++;
            if (t >= 300)
                $display("FAIL frame_done op=%h: tx got %0d bytes, required %0d", b0, got_tx.size(), exp_tx.size());
            else
                passes++;
        end
        repeat (4) @(posedge CLK);
    endtask

    task automatic test_reset();
        RST = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD} !== '0)
            $display("FAIL reset_outputs: got addr=%h we=%b re=%b wd=%h en=%b fun=%h cg=%b tx=%h tv=%b, required all 0",
                     RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD);
        else
            passes++;
        @(posedge CLK);
        #1;
        RST = 1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_write();
        clr();
        do_frame(8'hAA, 8'h05, 8'h3C, 8'h00, 3, 9, 0);
        checks++;
        if (!q_same(got_wr, exp_wr)) $display("FAIL write_rf: got %p, required %p", got_wr, exp_wr);
        else passes++;
        checks++;
        if (got_tx.size() != 0) $display("FAIL write_no_tx: got %0d pushes, required 0", got_tx.size());
        else passes++;
    endtask

    task automatic test_read();
        clr();
        do_frame(8'hBB, 8'h05, 8'h00, 8'h00, 2, 9, 1);
        checks++;
        if (!q_same(got_rd, exp_rd)) $display("FAIL read_req: got %p, required %p", got_rd, exp_rd);
        else passes++;
        checks++;
        if (!q_same(got_tx, exp_tx)) $display("FAIL read_tx: got %p, required %p", got_tx, exp_tx);
        else passes++;
    endtask

    task automatic test_alu();
        clr();
        do_frame(8'hCC, 8'h12, 8'h34, 8'h00, 4, 9, 1);
        checks++;
        if (!q_same(got_wr, exp_wr)) $display("FAIL alu_operands: got %p, required %p", got_wr, exp_wr);
        else passes++;
        checks++;
        if (!q_same(got_fun, exp_fun)) $display("FAIL alu_fun: got %p, required %p", got_fun, exp_fun);
        else passes++;
        checks++;
        if (!q_same(got_tx, exp_tx) || got_tx.size() != 2 || got_tx[0] !== 16'h0046)
            $display("FAIL alu_tx: got %p, required %p", got_tx, exp_tx);
        else passes++;
    endtask

    task automatic test_fifo_full();
        int t;
        clr();
        full_force = 1;
        @(posedge CLK);
        do_frame(8'hDD, 8'h01, 8'h00, 8'h00, 2, 9, 0);
        repeat (20) @(posedge CLK);
        checks++;
        if (got_tx.size() != 0) $display("FAIL full_stall: got %0d pushes, required 0", got_tx.size());
        else passes++;
        full_force = 0;
        t = 0;
        while (got_tx.size() < 2 && t < 100) begin
            @(posedge CLK);
            t++;
        end
        repeat (4) @(posedge CLK);
        checks++;
        if (!q_same(got_tx, exp_tx)) $display("FAIL full_release: got %p, required %p", got_tx, exp_tx);
        else passes++;
    endtask

    task automatic test_rx_error();
        clr();
        do_frame(8'hAA, 8'h07, 8'h99, 8'h00, 3, 2, 0);
        checks++;
        if (got_wr.size() != 0) $display("FAIL err_abort: got %0d writes, required 0", got_wr.size());
        else passes++;
        do_frame(8'hAA, 8'h07, 8'h11, 8'h00, 3, 9, 0);
        checks++;
        if (!q_same(got_wr, exp_wr)) $display("FAIL err_recover: got %p, required %p", got_wr, exp_wr);
        else passes++;
    endtask

    task automatic test_unknown_reset();
        clr();
        do_frame(8'h55, 8'h00, 8'h00, 8'h00, 1, 9, 0);
        checks++;
        if (got_wr.size() + got_rd.size() + got_tx.size() + got_fun.size() != 0)
            $display("FAIL unknown_op: got %0d side effects, required 0",
                     got_wr.size() + got_rd.size() + got_tx.size() + got_fun.size());
        else passes++;
        send_byte(8'hCC, 0);
        send_byte(8'h12, 0);
        exp_wr.push_back(16'h0012);
        model_rf[0] = 8'h12;
        repeat (2) @(posedge CLK);
        #1;
        RST = 0;
        #1;
        checks++;
        if ({RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_D_VLD} !== '0)
            $display("FAIL async_reset: got addr=%h wd=%h en=%b cg=%b, required 0", RF_ADDR, RF_WR_DATA, ALU_EN, CLK_GATE_EN);
        else passes++;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1;
        send_byte(8'h34, 0);
        send_byte(8'h00, 0);
        repeat (10) @(posedge CLK);
        checks++;
        if (got_fun.size() != 0 || !q_same(got_wr, exp_wr))
            $display("FAIL reset_abort: got writes %p funs %0d, required writes %p funs 0", got_wr, got_fun.size(), exp_wr);
        else passes++;
        do_frame(8'hAA, 8'h03, 8'h77, 8'h00, 3, 9, 0);
        checks++;
        if (!q_same(got_wr, exp_wr)) $display("FAIL post_reset_write: got %p, required %p", got_wr, exp_wr);
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] op, b1, b2, b3;
        int n, e, k;
        clr();
        full_rand = 1;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: begin op = 8'hAA; n = 3; end
                1: begin op = 8'hBB; n = 2; end
                2: begin op = 8'hCC; n = 4; end
                3: begin op = 8'hDD; n = 2; end
                default: begin
                    op = 8'($urandom_range(0, 255));
                    if (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD) op = 8'h55;
                    n = 1;
                end
            endcase
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            b3 = 8'($urandom_range(0, 255));
            e = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : 9;
            do_frame(op, b1, b2, b3, n, e, 1);
        end
        full_rand = 0;
        repeat (4) @(posedge CLK);
        checks++;
        if (!q_same(got_wr, exp_wr)) $display("FAIL rand_writes: got %0d, required %0d", got_wr.size(), exp_wr.size());
        else passes++;
        checks++;
        if (!q_same(got_rd, exp_rd)) $display("FAIL rand_reads: got %0d, required %0d", got_rd.size(), exp_rd.size());
        else passes++;
        checks++;
        if (!q_same(got_fun, exp_fun)) $display("FAIL rand_alu: got %0d, required %0d", got_fun.size(), exp_fun.size());
        else passes++;
        checks++;
        if (!q_same(got_tx, exp_tx)) $display("FAIL rand_tx: got %0d bytes, required %0d", got_tx.size(), exp_tx.size());
        else passes++;
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_err != 0) $display("FAIL protocol: got %0d violations, required 0", proto_err);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] = 8'($urandom_range(0, 255));
            model_rf[i] = rf_mem[i];
        end
        test_reset();
        test_write();
        test_read();
        test_alu();
        test_fifo_full();
        test_rx_error();
        test_unknown_reset();
        test_random();
        test_protocol();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
